// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and default sizing constants.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCompare,
    StDone
  } bist_state_e;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefPatterns = 255;
  localparam logic [15:0] DefPoly     = 16'h1021;

endpackage

// File: rtl/misr_16bit.sv
// Multiple-input signature register: shifts left with polynomial feedback and folds in d.
module misr_16bit
  import bist_pkg::*;
#(
  parameter int unsigned     WIDTH = DefWidth,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(DefPoly)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Next signature: shift, apply feedback when the MSB falls out, fold in the response.
  always_comb begin
    w_next = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? POLY : '0) ^ d;
  end

  // Signature register; clear has priority over compaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts PATTERNS responses into a MISR and compares to GOLDEN.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH    = DefWidth,
  parameter int unsigned      PATTERNS = DefPatterns,
  parameter logic [WIDTH-1:0] GOLDEN   = '0,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(DefPoly)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       count
);

  localparam logic [7:0] LastIdx = 8'(PATTERNS - 1);

  bist_state_e      r_state;
  bist_state_e      w_state_next;
  logic [7:0]       r_count;
  logic             r_pass;
  logic             w_clear;
  logic             w_en;
  logic             w_cmp;
  logic [WIDTH-1:0] w_sig;

  // Next-state and datapath strobes; start only honoured from IDLE/DONE, resp only in RUN.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_en         = 1'b0;
    w_cmp        = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (resp_valid) begin
          w_en = 1'b1;
          if (r_count == LastIdx) begin
            w_state_next = StCompare;
          end
        end
      end
      StCompare: begin
        w_cmp        = 1'b1;
        w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, response counter and compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_count <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_count <= '0;
        r_pass  <= 1'b0;
      end else if (w_en) begin
        r_count <= r_count + 8'd1;
      end
      if (w_cmp) begin
        r_pass <= (w_sig == GOLDEN);
      end
    end
  end

  misr_16bit #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .en    (w_en),
    .d     (resp),
    .q     (w_sig)
  );

  assign busy      = (r_state == StRun) || (r_state == StCompare);
  assign done      = (r_state == StDone);
  assign pass      = r_pass;
  assign signature = w_sig;
  assign count     = r_count;

endmodule
